// File: rtl/h80uart_tx_arb.sv
// Round-robin byte arbiter feeding a single UART transmitter: IDLE accept -> START (tx_en) -> DRAIN.
// Optional message lock (req_last holds ownership) enabled by defining H80_UART_ARB_LOCK_EN.
module h80uart_tx_arb #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_en,
  input  logic                   tx_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   err_timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]       last_q, last_d;
  logic                 tx_en_q, tx_en_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   ready_s;
  logic [IDW-1:0]       win_s;
  logic                 win_found_s;
  logic [IDW-1:0]       cand_v;

`ifdef H80_UART_ARB_LOCK_EN
  logic                 lock_q, lock_d;
  logic [IDW-1:0]       lock_id_q, lock_id_d;
`else
  logic                 unused_s;
  assign unused_s = ^req_last;
`endif

  // Winner selection: first valid requester after last_q, lowest distance wins.
  always_comb begin
    win_s       = last_q;
    win_found_s = 1'b0;
    cand_v      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_v = IDW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[cand_v]) begin
        win_s       = cand_v;
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
`ifdef H80_UART_ARB_LOCK_EN
    // A locked owner is the only candidate; others stall until its last byte.
    if (lock_q) begin
      win_s       = lock_id_q;
      win_found_s = req_valid[lock_id_q];
    end else begin
      win_s       = win_s;
    end
`endif
  end

  // Next-state and output computation for the IDLE/START/DRAIN sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tx_en_d   = 1'b0;
    err_d     = 1'b0;
    ready_s   = '0;
`ifdef H80_UART_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_found_s) begin
          ready_s[win_s] = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == IDW'(i)) begin
              tx_data_d = req_data[8*i +: 8];
            end else begin
              tx_data_d = tx_data_d;
            end
          end
          grant_d        = '0;
          grant_d[win_s] = 1'b1;
          last_d         = win_s;
          tx_en_d        = 1'b1;
          state_d        = ST_START;
`ifdef H80_UART_ARB_LOCK_EN
          lock_d    = ~req_last[win_s];
          lock_id_d = win_s;
`endif
        end else begin
          grant_d = '0;
        end
      end
      ST_START: begin
        if (tx_busy) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          // Transmitter never started: drop the byte and release ownership.
          state_d = ST_IDLE;
          err_d   = 1'b1;
          grant_d = '0;
          cnt_d   = '0;
`ifdef H80_UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          tx_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      grant_q   <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      tx_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tx_en_q   <= tx_en_d;
      err_q     <= err_d;
    end
  end

`ifdef H80_UART_ARB_LOCK_EN
  // Message lock ownership.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  // Accept strobe is combinational with valid, so it is held off while in reset.
  assign req_ready   = ready_s & {NUM_REQ{reset_n}};
  assign tx_data     = tx_data_q;
  assign tx_en       = tx_en_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_h80uart_tx_arb.sv
// Directed bench for h80uart_tx_arb (NUM_REQ=2, START_TIMEOUT=16); lock test when H80_UART_ARB_LOCK_EN is defined.
module tb_h80uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [1:0]  grant;
  logic        err_timeout;

  int vectors = 0;
  int errors  = 0;

  h80uart_tx_arb #(.NUM_REQ(2), .START_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en),
    .tx_busy(tx_busy), .grant(grant), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One byte with busy rising in the first START cycle: checks accept, START, DRAIN, return to IDLE.
  task automatic xfer(input string tag, input logic [1:0] exp_w, input logic [7:0] exp_d);
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(exp_w));
    @(negedge clk);
    #1;
    chk({tag, "_txen"},  32'(tx_en), 32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_w));
    chk({tag, "_data"},  32'(tx_data), 32'(exp_d));
    chk({tag, "_noerr"}, 32'(err_timeout), 32'd0);
    chk({tag, "_noready"}, 32'(req_ready), 32'd0);
    tx_busy = 1'b1;
    @(negedge clk);
    #1 chk({tag, "_drain_txen"}, 32'(tx_en), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    #1 chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b01;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    tx_busy   = 1'b0;

    // Reset state, with a requester already valid
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_txen",  32'(tx_en), 32'd0);
    chk("rst_err",   32'(err_timeout), 32'd0);
    chk("rst_data",  32'(tx_data), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    // Single byte 0x41 from req0, busy rises on the second START cycle
    @(negedge clk);
    req_valid = 2'b01;
    req_data  = 16'h0041;
    #1 chk("b1_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("b1_txen1", 32'(tx_en), 32'd1);
    chk("b1_data",  32'(tx_data), 32'h41);
    chk("b1_grant", 32'(grant), 32'd1);
    chk("b1_ready_off", 32'(req_ready), 32'd0);
    @(negedge clk);
    tx_busy = 1'b1;
    #1 chk("b1_txen2", 32'(tx_en), 32'd1);
    @(negedge clk);
    #1;
    chk("b1_txen_drop", 32'(tx_en), 32'd0);
    chk("b1_grant_drain", 32'(grant), 32'd1);
    @(negedge clk);
    tx_busy = 1'b0;
    #1 chk("b1_grant_busy", 32'(grant), 32'd1);
    @(negedge clk);
    #1;
    chk("b1_grant_clr", 32'(grant), 32'd0);
    chk("b1_idle_ready", 32'(req_ready), 32'd0);
    chk("b1_data_hold", 32'(tx_data), 32'h41);

`ifdef H80_UART_ARB_LOCK_EN
    // Lock: req0 message of three bytes preempts req1 even when req1 is next in rotation
    reset_pulse();
    req_valid = 2'b11;
    req_data  = 16'hB0_11;
    req_last  = 2'b10;
    xfer("lk1", 2'b01, 8'h11);
    req_valid = 2'b10;
    #1 chk("lk_stall_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 2'b11;
    req_data  = 16'hB0_22;
    xfer("lk2", 2'b01, 8'h22);
    req_data  = 16'hB0_33;
    req_last  = 2'b11;
    xfer("lk3", 2'b01, 8'h33);
    xfer("lk4", 2'b10, 8'hB0);
    req_valid = 2'b00;
    req_last  = 2'b00;
`else
    // Round-robin alternation with both requesters valid
    reset_pulse();
    req_valid = 2'b11;
    req_data  = 16'hB0_A0;
    req_last  = 2'b00;
    xfer("rr1", 2'b01, 8'hA0);
    xfer("rr2", 2'b10, 8'hB0);
    xfer("rr3", 2'b01, 8'hA0);
    xfer("rr4", 2'b10, 8'hB0);
    req_valid = 2'b00;
`endif

    // Start timeout: busy never rises
    reset_pulse();
    req_valid = 2'b11;
    req_data  = 16'hC5_5A;
    #1 chk("to_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      chk("to_txen_hi", 32'(tx_en), 32'd1);
      chk("to_err_lo", 32'(err_timeout), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("to_txen_drop", 32'(tx_en), 32'd0);
    chk("to_err_pulse", 32'(err_timeout), 32'd1);
    chk("to_grant_clr", 32'(grant), 32'd0);
    xfer("to_next", 2'b10, 8'hC5);
    req_valid = 2'b00;

    // Reset during DRAIN, then req1-only traffic
    req_valid = 2'b10;
    req_data  = 16'h5C_00;
    #1 chk("rd_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    #1;
    chk("rd_drain_grant", 32'(grant), 32'd2);
    chk("rd_drain_txen", 32'(tx_en), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rd_rst_txen",  32'(tx_en), 32'd0);
    chk("rd_rst_grant", 32'(grant), 32'd0);
    chk("rd_rst_ready", 32'(req_ready), 32'd0);
    chk("rd_rst_data",  32'(tx_data), 32'd0);
    @(negedge clk);
    tx_busy  = 1'b0;
    reset_n  = 1'b1;
    req_data = 16'hC3_00;
    xfer("rd_after", 2'b10, 8'hC3);
    req_valid = 2'b00;

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
